data_mem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single-ported DataMemory (7-bit word address, 32-bit data, combinational read, write on posedge Clk).
- Port 0 is the CPU load/store path; port 1 is the loader/debug path.
- Performs round-robin arbitration and drives MemRead/MemWrite/Address/WriteData to DataMemory for one cycle per access.
- Returns a one-cycle Ack pulse with registered read data to the winning requester.

---
 rtl/data_mem_arbiter_if.sv | 49 ++++
 rtl/data_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the data_mem_arbiter and DataMemory.
//   Requester side (per port n = 0/1): Req/Wr/Addr/WData in, Ack/RData out.
//   Memory side: MemAddress/MemWriteData/MemRead/MemWrite out, MemReadData in.
//   Busy: arbiter status.
// slave  = arbiter view, master = system view (requesters + DataMemory).
interface data_mem_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 7,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  Req0;
   logic                  Wr0;
   logic [ADDR_WIDTH-1:0] Addr0;
   logic [DATA_WIDTH-1:0] WData0;
   logic                  Ack0;
   logic [DATA_WIDTH-1:0] RData0;

   logic                  Req1;
   logic                  Wr1;
   logic [ADDR_WIDTH-1:0] Addr1;
   logic [DATA_WIDTH-1:0] WData1;
   logic                  Ack1;
   logic [DATA_WIDTH-1:0] RData1;

   logic [ADDR_WIDTH-1:0] MemAddress;
   logic [DATA_WIDTH-1:0] MemWriteData;
   logic                  MemRead;
   logic                  MemWrite;
   logic [DATA_WIDTH-1:0] MemReadData;

   logic                  Busy;

   modport slave (
      input  Req0, Wr0, Addr0, WData0,
      input  Req1, Wr1, Addr1, WData1,
      input  MemReadData,
      output Ack0, RData0, Ack1, RData1,
      output MemAddress, MemWriteData, MemRead, MemWrite,
      output Busy
   );

   modport master (
      output Req0, Wr0, Addr0, WData0,
      output Req1, Wr1, Addr1, WData1,
      output MemReadData,
      input  Ack0, RData0, Ack1, RData1,
      input  MemAddress, MemWriteData, MemRead, MemWrite,
      input  Busy
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter/sequencer in front of the single-ported DataMemory.
// Port 0 = CPU load/store, port 1 = loader/debug. Each grant runs
// IDLE -> ACCESS (one memory cycle) -> DONE (Ack pulse), so peak throughput
// is one access every three cycles.
// Ports:
//   Clk  - clock, all state updates on posedge
//   Rst  - synchronous active-low reset
//   bus  - data_mem_arbiter_if.slave: requester handshakes (Req/Wr/Addr/
//          WData in, Ack/RData out), memory drive (MemAddress/MemWriteData/
//          MemRead/MemWrite out, MemReadData in) and Busy.
module data_mem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 7,
   parameter int unsigned DATA_WIDTH = 32
) (
   input logic             Clk,
   input logic             Rst,
   data_mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } stateT;

   stateT                 state, nextState;
   logic                  sel, nextSel;
   logic                  last, nextLast;
   logic                  ack0, nextAck0;
   logic                  ack1, nextAck1;
   logic [DATA_WIDTH-1:0] rData0, nextRData0;
   logic [DATA_WIDTH-1:0] rData1, nextRData1;

   logic                  selWr;
   logic [ADDR_WIDTH-1:0] selAddr;
   logic [DATA_WIDTH-1:0] selWData;
   logic                  memRead;
   logic                  memWrite;

   // Selected port's request fields; also drive the memory outside ACCESS
   // so the address/data lines stay deterministic.
   always_comb begin
      selWr    = sel ? bus.Wr1    : bus.Wr0;
      selAddr  = sel ? bus.Addr1  : bus.Addr0;
      selWData = sel ? bus.WData1 : bus.WData0;
   end

   // State and datapath registers.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state  <= IDLE;
         sel    <= 1'b0;
         last   <= 1'b1;
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         rData0 <= '0;
         rData1 <= '0;
      end else begin
         state  <= nextState;
         sel    <= nextSel;
         last   <= nextLast;
         ack0   <= nextAck0;
         ack1   <= nextAck1;
         rData0 <= nextRData0;
         rData1 <= nextRData1;
      end
   end

   // Next-state, grant and memory-strobe logic.
   always_comb begin
      nextState  = state;
      nextSel    = sel;
      nextLast   = last;
      nextAck0   = 1'b0;
      nextAck1   = 1'b0;
      nextRData0 = rData0;
      nextRData1 = rData1;
      memRead    = 1'b0;
      memWrite   = 1'b0;

      case (state)
         IDLE: begin
            if (bus.Req0 && bus.Req1) begin
               // Contention: the port that did not win last time goes first.
               nextSel   = ~last;
               nextState = ACCESS;
            end else if (bus.Req0) begin
               nextSel   = 1'b0;
               nextState = ACCESS;
            end else if (bus.Req1) begin
               nextSel   = 1'b1;
               nextState = ACCESS;
            end
         end

         ACCESS: begin
            memRead  = ~selWr;
            // Rst gating keeps a write from landing on the edge that resets us.
            memWrite = selWr & Rst;
            if (!selWr) begin
               if (sel) nextRData1 = bus.MemReadData;
               else     nextRData0 = bus.MemReadData;
            end
            if (sel) nextAck1 = 1'b1;
            else     nextAck0 = 1'b1;
            nextLast  = sel;
            nextState = DONE;
         end

         DONE: begin
            nextState = IDLE;
         end

         default: begin
            nextState = IDLE;
         end
      endcase
   end

   assign bus.MemAddress   = selAddr;
   assign bus.MemWriteData = selWData;
   assign bus.MemRead      = memRead;
   assign bus.MemWrite     = memWrite;
   assign bus.Ack0         = ack0;
   assign bus.Ack1         = ack1;
   assign bus.RData0       = rData0;
   assign bus.RData1       = rData1;
   assign bus.Busy         = (state != IDLE);

   // Structural invariants of the sequencer.
   ackExclusive : assert property (@(posedge Clk) disable iff (!Rst) !(ack0 && ack1));
   memExclusive : assert property (@(posedge Clk) disable iff (!Rst) !(memRead && memWrite));

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

   localparam int unsigned AW = 7;
   localparam int unsigned DW = 32;
   localparam int unsigned DEPTH = 128;
   localparam int ACK_TIMEOUT = 30;

   typedef struct packed {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } expT;

   logic Clk;
   logic Rst;
   int   checks;
   int   failures;
   int   cyc;

   data_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   data_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   // DataMemory environment: combinational read, write on posedge.
   logic [DW-1:0] tbMem [DEPTH];
   assign bus.MemReadData = tbMem[bus.MemAddress];
   always @(posedge Clk) begin
      if (bus.MemWrite) tbMem[bus.MemAddress] <= bus.MemWriteData;
   end

   // Reference model: memory contents as the requesters should see them.
   logic [DW-1:0] refMem [DEPTH];
   expT exp0[$];
   expT exp1[$];
   logic [DW-1:0] held0, held1;
   int ackPort[$];
   int ackCyc[$];

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic setReq(input int port, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit push);
      expT e;
      e.wr   = wr;
      e.addr = a;
      e.data = wr ? d : refMem[a];
      if (push) begin
         if (wr) refMem[a] = d;
         if (port == 0) exp0.push_back(e);
         else           exp1.push_back(e);
      end
      if (port == 0) begin
         bus.Wr0 = wr; bus.Addr0 = a; bus.WData0 = d; bus.Req0 = 1'b1;
      end else begin
         bus.Wr1 = wr; bus.Addr1 = a; bus.WData1 = d; bus.Req1 = 1'b1;
      end
   endtask

   task automatic clrReq(input int port);
      if (port == 0) bus.Req0 = 1'b0;
      else           bus.Req1 = 1'b0;
   endtask

   // Issue one access and hold Req until Ack is seen (Req drops in DONE).
   task automatic access(input int port, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
      int  n;
      logic ack;
      setReq(port, wr, a, d, 1'b1);
      n   = 0;
      ack = 1'b0;
      while (!ack && n < ACK_TIMEOUT) begin
         tick();
         n++;
         ack = (port == 0) ? bus.Ack0 : bus.Ack1;
      end
      if (!ack) begin
         failures++;
         checks++;
         $display("FAIL ack_timeout port=%0d actual=no_ack required=ack within %0d cycles", port, ACK_TIMEOUT);
      end
      clrReq(port);
   endtask

   task automatic randPort(input int port, input int count);
      for (int i = 0; i < count; i++) begin
         int gap;
         logic wr;
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         gap = int'($urandom_range(0, 3));
         repeat (gap) tick();
         wr = 1'($urandom_range(0, 1));
         a  = (port == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(64, 127));
         d  = $urandom;
         access(port, wr, a, d);
      end
   endtask

   task automatic doReset();
      Rst = 1'b0;
      repeat (2) tick();
      Rst = 1'b1;
   endtask

   // Monitor: pops expected responses on each Ack and checks invariants.
   always @(negedge Clk) begin
      if (!Rst) begin
         held0 = '0;
         held1 = '0;
         exp0.delete();
         exp1.delete();
      end else begin
         chk("ack_overlap", {31'd0, bus.Ack0 & bus.Ack1}, 32'd0);
         chk("mem_rw_overlap", {31'd0, bus.MemRead & bus.MemWrite}, 32'd0);
         if (bus.Ack0) begin
            ackPort.push_back(0);
            ackCyc.push_back(cyc);
            if (exp0.size() == 0) begin
               chk("unexpected_ack0", 32'd1, 32'd0);
            end else begin
               expT e;
               e = exp0.pop_front();
               if (!e.wr) held0 = e.data;
            end
         end
         if (bus.Ack1) begin
            ackPort.push_back(1);
            ackCyc.push_back(cyc);
            if (exp1.size() == 0) begin
               chk("unexpected_ack1", 32'd1, 32'd0);
            end else begin
               expT e;
               e = exp1.pop_front();
               if (!e.wr) held1 = e.data;
            end
         end
         chk("rdata0", bus.RData0, held0);
         chk("rdata1", bus.RData1, held1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks   = 0;
      failures = 0;
      cyc      = 0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         tbMem[i]  = DW'(i * 7 + 3);
         refMem[i] = DW'(i * 7 + 3);
      end
      Rst = 1'b0;
      bus.Req0 = 1'b0; bus.Wr0 = 1'b0; bus.Addr0 = '0; bus.WData0 = '0;
      bus.Req1 = 1'b0; bus.Wr1 = 1'b0; bus.Addr1 = '0; bus.WData1 = '0;

      // Reset state
      repeat (2) tick();
      chk("rst_ack0", {31'd0, bus.Ack0}, 32'd0);
      chk("rst_ack1", {31'd0, bus.Ack1}, 32'd0);
      chk("rst_rdata0", bus.RData0, 32'd0);
      chk("rst_rdata1", bus.RData1, 32'd0);
      chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
      chk("rst_memwrite", {31'd0, bus.MemWrite}, 32'd0);
      Rst = 1'b1;
      tick();

      // Port 0 write 1000 to address 2: strobe in cycle 1, Ack in cycle 2
      setReq(0, 1'b1, AW'(2), 32'd1000, 1'b1);
      tick();
      chk("t1_memwrite", {31'd0, bus.MemWrite}, 32'd1);
      chk("t1_memread", {31'd0, bus.MemRead}, 32'd0);
      chk("t1_memaddr", {25'd0, bus.MemAddress}, 32'd2);
      chk("t1_memwdata", bus.MemWriteData, 32'd1000);
      chk("t1_busy", {31'd0, bus.Busy}, 32'd1);
      chk("t1_ack0_early", {31'd0, bus.Ack0}, 32'd0);
      tick();
      chk("t1_ack0", {31'd0, bus.Ack0}, 32'd1);
      chk("t1_memwrite_off", {31'd0, bus.MemWrite}, 32'd0);
      chk("t1_mem2", tbMem[2], 32'd1000);
      clrReq(0);
      tick();

      // Port 0 read back address 2
      setReq(0, 1'b0, AW'(2), 32'd0, 1'b1);
      tick();
      chk("t2_memread", {31'd0, bus.MemRead}, 32'd1);
      chk("t2_memaddr", {25'd0, bus.MemAddress}, 32'd2);
      tick();
      chk("t2_ack0", {31'd0, bus.Ack0}, 32'd1);
      chk("t2_rdata0", bus.RData0, 32'd1000);
      chk("t2_rdata1", bus.RData1, 32'd0);
      chk("t2_memread_off", {31'd0, bus.MemRead}, 32'd0);
      clrReq(0);
      tick();

      // Simultaneous reads from reset: port 0 first, Ack1 three cycles later
      doReset();
      ackPort.delete();
      ackCyc.delete();
      fork
         access(0, 1'b0, AW'(8), 32'd0);
         access(1, 1'b0, AW'(9), 32'd0);
      join
      tick();
      if (ackPort.size() >= 2) begin
         chk("t3_first_port", 32'(ackPort[0]), 32'd0);
         chk("t3_second_port", 32'(ackPort[1]), 32'd1);
         chk("t3_ack_spacing", 32'(ackCyc[1] - ackCyc[0]), 32'd3);
      end else begin
         chk("t3_ack_count", 32'(ackPort.size()), 32'd2);
      end

      // Continuous contention: grants alternate 0,1,0,1,0,1
      doReset();
      ackPort.delete();
      ackCyc.delete();
      fork
         repeat (3) access(0, 1'b0, AW'($urandom_range(0, 63)), 32'd0);
         repeat (3) access(1, 1'b0, AW'($urandom_range(64, 127)), 32'd0);
      join
      tick();
      chk("t4_grant_count", 32'(ackPort.size()), 32'd6);
      for (int i = 0; i < ackPort.size() && i < 6; i++) begin
         chk($sformatf("t4_grant%0d", i), 32'(ackPort[i]), 32'(i % 2));
      end

      // Reset during a port 1 write ACCESS: no commit, back to IDLE
      setReq(1, 1'b1, AW'(9), 32'd1234, 1'b0);
      tick();
      chk("t5_memwrite_pre", {31'd0, bus.MemWrite}, 32'd1);
      Rst = 1'b0;
      #1;
      chk("t5_memwrite_gated", {31'd0, bus.MemWrite}, 32'd0);
      tick();
      chk("t5_busy", {31'd0, bus.Busy}, 32'd0);
      chk("t5_ack1", {31'd0, bus.Ack1}, 32'd0);
      chk("t5_mem9", tbMem[9], refMem[9]);
      clrReq(1);
      Rst = 1'b1;
      tick();
      access(1, 1'b0, AW'(9), 32'd0);
      tick();

      // Idle: no strobes, no Busy, no Acks
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t6_idle_strobes", {30'd0, bus.MemRead, bus.MemWrite}, 32'd0);
         chk("t6_idle_busy_ack", {29'd0, bus.Busy, bus.Ack0, bus.Ack1}, 32'd0);
      end

      // Randomized traffic, disjoint address halves per port
      fork
         randPort(0, 40);
         randPort(1, 40);
      join
      repeat (6) tick();
      chk("drain_exp0", 32'(exp0.size()), 32'd0);
      chk("drain_exp1", 32'(exp1.size()), 32'd0);
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (tbMem[i] !== refMem[i]) chk($sformatf("final_mem%0d", i), tbMem[i], refMem[i]);
      end
      chk("final_mem_sample", tbMem[2], refMem[2]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
